// File: rtl/sp_lector_banco.sv
// sp_lector_banco: sequential read master for the single-port register bank.
// Sweeps first_addr..last_addr (inclusive, wrapping modulo 2^A) and streams
// each word over a valid/ready interface, one word per cycle at full rate.
// Optional feature macro: SP_LECTOR_BANCO_CHECKSUM_EN adds an XOR checksum
// output over all words accepted during the sweep.
module sp_lector_banco #(
  parameter int W = 8,
  parameter int A = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [A-1:0] first_addr,
  input  logic [A-1:0] last_addr,
  input  logic         abort,
  output logic [A-1:0] mem_address,
  input  logic [W-1:0] mem_data,
  output logic [W-1:0] out_data,
  output logic [A-1:0] out_addr,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy,
  output logic         done
`ifdef SP_LECTOR_BANCO_CHECKSUM_EN
  ,
  output logic [W-1:0] checksum
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_STREAM
  } state_t;

  state_t       state_q, state_d;
  logic [A-1:0] cnt_q, cnt_d;
  logic [A-1:0] end_q, end_d;
  logic         last_q, last_d;
  logic [W-1:0] out_data_q, out_data_d;
  logic [A-1:0] out_addr_q, out_addr_d;
  logic         out_valid_q, out_valid_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         capture;
  logic         handshake;
`ifdef SP_LECTOR_BANCO_CHECKSUM_EN
  logic [W-1:0] csum_q, csum_d;
`endif

  // The counter only moves during a sweep, so it doubles as the bank address
  // and naturally holds its last driven value while idle.
  assign mem_address = cnt_q;
  assign out_data    = out_data_q;
  assign out_addr    = out_addr_q;
  assign out_valid   = out_valid_q;
  assign busy        = busy_q;
  assign done        = done_q;
`ifdef SP_LECTOR_BANCO_CHECKSUM_EN
  assign checksum    = csum_q;
`endif

  assign handshake = out_valid_q & out_ready;

  // Next-state logic: sequencing, word capture and counter advance.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    end_d       = end_q;
    last_d      = last_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;
    capture     = 1'b0;
`ifdef SP_LECTOR_BANCO_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d   = first_addr;
          end_d   = last_addr;
          state_d = S_FETCH;
`ifdef SP_LECTOR_BANCO_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      S_FETCH: begin
        if (abort) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
        end else begin
          capture = 1'b1;
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        if (abort) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
        end else if (handshake) begin
`ifdef SP_LECTOR_BANCO_CHECKSUM_EN
          csum_d = csum_q ^ out_data_q;
`endif
          if (last_q) begin
            out_valid_d = 1'b0;
            done_d      = 1'b1;
            state_d     = S_IDLE;
          end else begin
            capture = 1'b1;
          end
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
      end
    endcase

    // The word at the counter is snapshotted; the counter stops on the end
    // address so it still points at the final word after the sweep.
    if (capture) begin
      out_data_d  = mem_data;
      out_addr_d  = cnt_q;
      out_valid_d = 1'b1;
      last_d      = (cnt_q == end_q);
      if (cnt_q != end_q) begin
        cnt_d = cnt_q + A'(1);
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      end_q       <= '0;
      last_q      <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef SP_LECTOR_BANCO_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      end_q       <= end_d;
      last_q      <= last_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef SP_LECTOR_BANCO_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_sp_lector_banco.sv
// Scoreboard bench for sp_lector_banco: the bank is modelled as an array,
// expected words are queued when a sweep starts and popped by a monitor on
// every handshake.
module tb_sp_lector_banco;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       abort;
  logic [3:0] first_addr;
  logic [3:0] last_addr;
  logic [3:0] mem_address;
  logic [7:0] mem_data;
  logic [7:0] out_data;
  logic [3:0] out_addr;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       done;
`ifdef SP_LECTOR_BANCO_CHECKSUM_EN
  logic [7:0] checksum;
`endif

  logic [7:0] mem [16];

  typedef struct {
    logic [3:0] addr;
    logic [7:0] data;
    bit         last;
    logic [7:0] csum;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  assign mem_data = mem[mem_address];

  sp_lector_banco #(.W(8), .A(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .first_addr  (first_addr),
    .last_addr   (last_addr),
    .abort       (abort),
    .mem_address (mem_address),
    .mem_data    (mem_data),
    .out_data    (out_data),
    .out_addr    (out_addr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy),
    .done        (done)
`ifdef SP_LECTOR_BANCO_CHECKSUM_EN
    ,
    .checksum    (checksum)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the sweep is every address from f stepping by one modulo 16
  // until l, inclusive; data is whatever the bank holds there now.
  task automatic push_sweep(input logic [3:0] f, input logic [3:0] l);
    logic [3:0] a  = f;
    logic [7:0] cs = 8'h00;
    for (int k = 0; k < 16; k++) begin
      exp_t e;
      cs     = cs ^ mem[a];
      e.addr = a;
      e.data = mem[a];
      e.last = (a == l);
      e.csum = cs;
      q.push_back(e);
      if (a == l) break;
      a = a + 4'd1;
    end
  endtask

  task automatic monitor_loop();
    bit         pend_done = 1'b0;
    logic [7:0] pend_cs   = 8'h00;
    forever begin
      @(negedge clk);
      if (reset) begin
        q.delete();
        pend_done = 1'b0;
      end else begin
        bit new_pend = 1'b0;
        chk("done_pulse", done, pend_done);
`ifdef SP_LECTOR_BANCO_CHECKSUM_EN
        if (pend_done) chk("checksum", checksum, pend_cs);
`endif
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            chk("unexpected_word", 32'd1, 32'd0);
          end else begin
            exp_t e = q.pop_front();
            chk("out_addr", out_addr, e.addr);
            chk("out_data", out_data, e.data);
            new_pend = e.last;
            pend_cs  = e.csum;
          end
        end
        if (abort && busy) begin
          q.delete();
          new_pend = 1'b0;
        end
        pend_done = new_pend;
      end
    end
  endtask

  // mode 0: ready held high; 1: ready pattern 1,0,0,1,...; 2: random ready.
  task automatic run_sweep(input logic [3:0] f, input logic [3:0] l, input int mode,
                           input bit chk_lat);
    int n   = int'(4'(l - f)) + 1;
    bit got = 1'b0;
    bit wrote = 1'b0;
    first_addr = f;
    last_addr  = l;
    start      = 1'b1;
    out_ready  = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
    push_sweep(f, l);
    for (int c = 1; c <= 400; c++) begin
      @(posedge clk);
      #1;
      first_addr = 4'($urandom);
      last_addr  = 4'($urandom);
      start      = busy ? ($urandom_range(0, 3) == 0) : 1'b0;
      if (chk_lat && c == 1) begin
        chk("busy_after_start", busy, 1);
        chk("valid_not_yet", out_valid, 0);
      end
      if (chk_lat && c == 2) chk("first_valid", out_valid, 1);
      if (done) begin
        if (chk_lat) chk("start_to_done", c - 1, n + 1);
        chk("mem_address_hold", mem_address, l);
        chk("busy_at_done", busy, 0);
        got = 1'b1;
        break;
      end
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (c % 3 == 0);
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
      if (mode == 1 && !wrote && out_valid && out_addr == 4'd3 && !out_ready) begin
        mem[3] = 8'hFF;
        wrote  = 1'b1;
      end
    end
    start = 1'b0;
    if (!got) chk("done_timeout", 0, 1);
    if (mode == 1) chk("bank_write_hit", wrote, 1);
    mem[3] = 8'h13;
  endtask

  task automatic abort_test();
    bit hit = 1'b0;
    first_addr = 4'd4;
    last_addr  = 4'd10;
    start      = 1'b1;
    out_ready  = 1'b1;
    push_sweep(4'd4, 4'd10);
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      first_addr = 4'($urandom);
      last_addr  = 4'($urandom);
      start      = busy;
      if (out_valid && out_addr == 4'd5) begin
        abort = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("abort_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        hit = 1'b1;
        break;
      end
    end
    start = 1'b0;
    chk("abort_reached", hit, 1);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk("abort_no_done", done, 0);
      chk("abort_idle", busy, 0);
    end
  endtask

  task automatic reset_test();
    first_addr = 4'd0;
    last_addr  = 4'd15;
    start      = 1'b1;
    out_ready  = 1'b1;
    push_sweep(4'd0, 4'd15);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    chk("pre_reset_valid", out_valid, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data", out_data, 0);
    chk("rst_addr", out_addr, 0);
    chk("rst_mem_address", mem_address, 0);
    chk("rst_done", done, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("post_reset_no_done", done, 0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h10 + 8'(i);
    reset      = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    out_ready  = 1'b0;
    first_addr = 4'd0;
    last_addr  = 4'd0;
    fork
      monitor_loop();
    join_none
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset_valid", out_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_data", out_data, 0);
    chk("reset_out_addr", out_addr, 0);
    chk("reset_mem_address", mem_address, 0);
`ifdef SP_LECTOR_BANCO_CHECKSUM_EN
    chk("reset_checksum", checksum, 0);
`endif
    reset = 1'b0;
    @(posedge clk);
    #1;

    run_sweep(4'd2, 4'd5, 0, 1'b1);
    run_sweep(4'd14, 4'd1, 0, 1'b1);
    run_sweep(4'd0, 4'd6, 1, 1'b0);
    run_sweep(4'd7, 4'd7, 0, 1'b1);
    run_sweep(4'd3, 4'd9, 0, 1'b1);
    abort_test();
    run_sweep(4'd5, 4'd4, 0, 1'b1);
    reset_test();
    run_sweep(4'd2, 4'd5, 0, 1'b1);
    for (int t = 0; t < 20; t++) begin
      run_sweep(4'($urandom), 4'($urandom), 2, 1'b0);
      if ($urandom_range(0, 1) == 0) begin
        @(posedge clk);
        #1;
      end
    end

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
